// File: rtl/writeback_queue_pkg.sv
// Shared widths and the queued-entry layout for the writeback queue.
package writeback_queue_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned ENTRY_W   = REG_IDX_W + DATA_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    val;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_wb_fifo.sv
// Circular entry store with wrapping pointers, occupancy count and per-slot valid flags.
module writeback_queue_wb_fifo
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic [ENTRY_W-1:0]               wdata_i,
  input  logic                             pop_i,
  output logic [ENTRY_W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic [DEPTH-1:0]                 slot_valid_o,
  output logic [DEPTH*REG_IDX_W-1:0]       slot_idx_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop_i);
    wr_ptr_d = wr_ptr_q + PtrW'(push_i);
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is never cleared; validity comes from the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    slot_valid_o = '0;
    slot_idx_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PtrW-1:0] off;
      off = PtrW'(i) - rd_ptr_q;
      slot_valid_o[i] = CntW'(off) < count_q;
      slot_idx_o[i*REG_IDX_W +: REG_IDX_W] = mem_q[i][ENTRY_W-1 -: REG_IDX_W];
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Serialises ALU and load results into a single register-file write port, ALU first.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]    alu_val,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]    mem_val,
  output logic                 mem_ready,
  output logic                 write_en,
  output logic [REG_IDX_W-1:0] writeReg,
  output logic [DATA_W-1:0]    write_val,
  output logic [NUM_REGS-1:0]  pending_mask,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                       push;
  wb_entry_t                  push_entry;
  wb_entry_t                  head;
  logic [CntW-1:0]            count;
  logic [DEPTH-1:0]           slot_valid;
  logic [DEPTH*REG_IDX_W-1:0] slot_idx;

  // Reset forces the idle view immediately, even before the count register clears.
  assign full  = !rst && (count == CntW'(DEPTH));
  assign empty = rst || (count == '0);

  assign alu_ready = !full;
  assign mem_ready = !full && !alu_valid;
  assign push      = (alu_valid && alu_ready) || (mem_valid && mem_ready);

  always_comb begin
    push_entry = '0;
    if (alu_valid) begin
      push_entry.idx = alu_reg;
      push_entry.val = alu_val;
    end else begin
      push_entry.idx = mem_reg;
      push_entry.val = mem_val;
    end
  end

  assign write_en  = clk_en && !empty;
  assign writeReg  = head.idx;
  assign write_val = head.val;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && !rst) begin
        pending_mask[slot_idx[i*REG_IDX_W +: REG_IDX_W]] = 1'b1;
      end
    end
  end

  writeback_queue_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .wdata_i     (push_entry),
    .pop_i       (write_en),
    .rdata_o     (head),
    .count_o     (count),
    .slot_valid_o(slot_valid),
    .slot_idx_o  (slot_idx)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed stimulus against a queue-based model of the writeback queue.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_reg = '0;
  logic [31:0] alu_val = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_reg = '0;
  logic [31:0] mem_val = '0;
  logic        mem_ready;
  logic        write_en;
  logic [2:0]  writeReg;
  logic [31:0] write_val;
  logic [7:0]  pending_mask;
  logic        full;
  logic        empty;

  int checks = 0;
  int failures = 0;

  int          q_reg [$];
  logic [31:0] q_val [$];

  always #5 clk = ~clk;

  writeback_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .alu_valid   (alu_valid),
    .alu_reg     (alu_reg),
    .alu_val     (alu_val),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_reg     (mem_reg),
    .mem_val     (mem_val),
    .mem_ready   (mem_ready),
    .write_en    (write_en),
    .writeReg    (writeReg),
    .write_val   (write_val),
    .pending_mask(pending_mask),
    .full        (full),
    .empty       (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs at negedge against the model, then advance the model.
  task automatic step(input logic r, input logic ce,
                      input logic av, input logic [2:0] ar, input logic [31:0] aval,
                      input logic mv, input logic [2:0] mr, input logic [31:0] mval);
    logic       e_full, e_empty, e_we;
    logic [7:0] e_mask;
    rst = r; clk_en = ce;
    alu_valid = av; alu_reg = ar; alu_val = aval;
    mem_valid = mv; mem_reg = mr; mem_val = mval;
    @(negedge clk);
    e_full  = !r && (q_reg.size() == DEPTH);
    e_empty = r || (q_reg.size() == 0);
    e_we    = ce && !e_empty;
    e_mask  = '0;
    if (!r) foreach (q_reg[k]) e_mask[q_reg[k]] = 1'b1;
    check("write_en", write_en, e_we);
    if (e_we) begin
      check("writeReg", writeReg, q_reg[0]);
      check("write_val", write_val, q_val[0]);
    end
    check("alu_ready", alu_ready, !e_full);
    check("mem_ready", mem_ready, !e_full && !av);
    check("full", full, e_full);
    check("empty", empty, e_empty);
    check("pending_mask", pending_mask, e_mask);
    @(posedge clk);
    if (r) begin
      q_reg.delete();
      q_val.delete();
    end else begin
      if (e_we) begin
        void'(q_reg.pop_front());
        void'(q_val.pop_front());
      end
      if (av && !e_full) begin
        q_reg.push_back(ar); q_val.push_back(aval);
      end else if (mv && !e_full) begin
        q_reg.push_back(mr); q_val.push_back(mval);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ce);
    step(1'b0, ce, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 32'h5, 1'b0, 3'd0, 32'd0);

    // Single ALU write, one-cycle latency.
    step(1'b0, 1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Simultaneous offers: ALU wins, load re-offered.
    step(1'b0, 1'b1, 1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 32'h22);
    idle(1'b1);
    idle(1'b1);

    // Fill while stalled, refuse when full, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 3'(i), 32'h100 + i, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 3'd7, 32'hBAD, 1'b1, 3'd6, 32'hBAD);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Duplicate destination.
    step(1'b0, 1'b0, 1'b1, 3'd5, 32'h1, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 32'h2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 3'(i + 4), 32'h200 + i, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    idle(1'b1);

    // Steady push+pop across pointer wrap.
    step(1'b0, 1'b0, 1'b1, 3'd6, 32'h300, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 3'd7, 32'h301, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 3'(i), 32'h400 + i, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 5), 3'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
